// File: rtl/pl_imm_gen_stage_if.sv
// ============================================================================
//  Module      : pl_imm_gen_stage_if
//  Description : Handshake and data bundle for the immediate-generation stage.
//                The master side drives instructions in and accepts results;
//                the slave side is the stage itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pl_imm_gen_stage_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    // Upstream (fetch) side
    logic            in_valid;
    logic            in_ready;
    logic [ILEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic [2:0]      in_immsrc;

    // Downstream (decode) side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_target;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, in_immsrc, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_instr, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_immsrc, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_instr, out_pc
    );
endinterface

`default_nettype wire

// File: rtl/pl_imm_gen_stage.sv
// ============================================================================
//  Module      : pl_imm_gen_stage
//  Description : Registered immediate-generation stage between fetch and
//                decode. Decodes every immediate format, precomputes the
//                PC-relative target, and buffers through a 2-entry skid so
//                in_ready never depends combinationally on out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pl_imm_gen_stage #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         flush,
    pl_imm_gen_stage_if.slave bus
);

    // Shift amounts are 6 bits wide on RV64, 5 on RV32.
    localparam int SHW = (XLEN == 64) ? 6 : 5;

    localparam logic [2:0] FMT_I  = 3'b000;
    localparam logic [2:0] FMT_S  = 3'b001;
    localparam logic [2:0] FMT_B  = 3'b010;
    localparam logic [2:0] FMT_U  = 3'b011;
    localparam logic [2:0] FMT_J  = 3'b100;
    localparam logic [2:0] FMT_IU = 3'b101;
    localparam logic [2:0] FMT_Z  = 3'b110;
    localparam logic [2:0] FMT_SH = 3'b111;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
    } entry_t;

    entry_t          main_q;
    entry_t          skid_q;
    logic            main_valid;
    logic            skid_valid;

    logic [XLEN-1:0] imm_dec;
    entry_t          in_entry;
    logic            accept;
    logic            main_free;

    // Immediate decode for the incoming instruction, selected by format.
    always_comb begin
        imm_dec = '0;
        case (bus.in_immsrc)
            FMT_I:  imm_dec = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
            FMT_S:  imm_dec = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25],
                               bus.in_instr[11:7]};
            FMT_B:  imm_dec = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[7],
                               bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
            // Bit 31 is replicated upward so lui/auipc sign-extend on RV64.
            FMT_U:  imm_dec = {{(XLEN-31){bus.in_instr[31]}}, bus.in_instr[30:12], 12'b0};
            FMT_J:  imm_dec = {{(XLEN-20){bus.in_instr[31]}}, bus.in_instr[19:12],
                               bus.in_instr[20], bus.in_instr[30:21], 1'b0};
            FMT_IU: imm_dec = {{(XLEN-12){1'b0}}, bus.in_instr[31:20]};
            FMT_Z:  imm_dec = {{(XLEN-5){1'b0}}, bus.in_instr[19:15]};
            FMT_SH: imm_dec = {{(XLEN-SHW){1'b0}}, bus.in_instr[20 +: SHW]};
            default: imm_dec = '0;
        endcase
    end

    // Assemble the entry that would be captured on an input transfer.
    always_comb begin
        in_entry.instr  = bus.in_instr;
        in_entry.pc     = bus.in_pc;
        in_entry.imm    = imm_dec;
        in_entry.target = bus.in_pc + imm_dec;
    end

    // The skid slot being empty is the only condition for accepting, so a
    // stalled main entry always has somewhere to park the next arrival.
    assign accept    = bus.in_valid && !skid_valid;
    assign main_free = !main_valid || bus.out_ready;

    // Main/skid storage: skid refills main first to keep arrival order;
    // flush kills both slots and drops any same-cycle input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= in_entry;
                end
            end
        end else if (accept) begin
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
        end
    end

    assign bus.in_ready   = !skid_valid;
    assign bus.out_valid  = main_valid;
    assign bus.out_imm    = main_q.imm;
    assign bus.out_target = main_q.target;
    assign bus.out_instr  = main_q.instr;
    assign bus.out_pc     = main_q.pc;

endmodule

`default_nettype wire

// File: tb/tb_pl_imm_gen_stage.sv
// ============================================================================
//  Module      : tb_pl_imm_gen_stage
//  Description : Self-checking bench for pl_imm_gen_stage (RV32 and RV64).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pl_imm_gen_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    pl_imm_gen_stage_if #(.XLEN(32), .ILEN(32)) bus ();
    pl_imm_gen_stage_if #(.XLEN(64), .ILEN(32)) bus64 ();

    pl_imm_gen_stage #(.XLEN(32), .ILEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    pl_imm_gen_stage #(.XLEN(64), .ILEN(32)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus64)
    );

    typedef struct {
        logic [31:0] imm;
        logic [31:0] target;
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   rnd_mode  = 1'b0;
    logic ready_val = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference immediate decode, computed at 64 bits then narrowed for RV32.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s, input bit x64);
        logic [63:0] r;
        case (s)
            3'd0: r = {{52{i[31]}}, i[31:20]};
            3'd1: r = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd2: r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: r = {{32{i[31]}}, i[31:12], 12'h000};
            3'd4: r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd5: r = {52'h0, i[31:20]};
            3'd6: r = {59'h0, i[19:15]};
            default: r = x64 ? {58'h0, i[25:20]} : {59'h0, i[24:20]};
        endcase
        return x64 ? r : {32'h0, r[31:0]};
    endfunction

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] eimm);
        exp_t e;
        e.imm    = eimm;
        e.target = pc + eimm;
        e.instr  = ins;
        e.pc     = pc;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Downstream ready: fixed level or random per cycle.
    always @(posedge clk) begin
        #2;
        bus.out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Scoreboard monitor: every output transfer pops and compares one entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_pop", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("out_imm",    64'(bus.out_imm),    64'(e.imm));
                check("out_target", 64'(bus.out_target), 64'(e.target));
                check("out_instr",  64'(bus.out_instr),  64'(e.instr));
                check("out_pc",     64'(bus.out_pc),     64'(e.pc));
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Present one instruction and hold it until the stage accepts it.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [2:0] src, input logic [31:0] eimm);
        bus.in_valid  = 1'b1;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.in_immsrc = src;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(mk(ins, pc, eimm));
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0 && !bus.out_valid) return;
            @(posedge clk); #1;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins;
        logic [31:0] pc;
        logic [2:0]  src;
        int          n;

        bus.in_valid    = 1'b0;
        bus.in_instr    = '0;
        bus.in_pc       = '0;
        bus.in_immsrc   = '0;
        bus64.in_valid  = 1'b0;
        bus64.in_instr  = '0;
        bus64.in_pc     = '0;
        bus64.in_immsrc = '0;
        bus64.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_in_ready",   64'(bus.in_ready),   64'd1);
        check("rst_out_imm",    64'(bus.out_imm),    64'd0);
        check("rst_out_target", 64'(bus.out_target), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // RV64: lui sign extension, then 6-bit shamt
        bus64.in_valid  = 1'b1;
        bus64.in_instr  = 32'h800002B7;
        bus64.in_pc     = 64'h0;
        bus64.in_immsrc = 3'b011;
        @(posedge clk); #1;
        bus64.in_instr  = 32'h03F01013;
        bus64.in_pc     = 64'h10;
        bus64.in_immsrc = 3'b111;
        @(negedge clk);
        check("x64_lui_valid",  64'(bus64.out_valid), 64'd1);
        check("x64_lui_imm",    bus64.out_imm,        64'hFFFFFFFF80000000);
        check("x64_lui_target", bus64.out_target,     64'hFFFFFFFF80000000);
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        @(negedge clk);
        check("x64_sh_imm",    bus64.out_imm,    64'd63);
        check("x64_sh_target", bus64.out_target, 64'h4F);
        @(posedge clk); #1;

        // RV32 directed formats
        send(32'hFFF00093, 32'h100,  3'b000, 32'hFFFFFFFF);
        send(32'hFE000EE3, 32'h1000, 3'b010, 32'hFFFFFFFC);
        send(32'h03F01013, 32'h0,    3'b111, 32'd31);
        for (int s = 0; s < 8; s++) begin
            ins = 32'h8A5C3F5B ^ (32'h1357_9BDF * s);
            send(ins, 32'h2000 + 32'(s * 4), 3'(s), ref_imm(ins, 3'(s), 1'b0));
        end
        wait_drain();

        // Back-pressure: A held, B parks in skid, C waits
        ready_val = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00A00093;
        bus.in_pc     = 32'h300;
        bus.in_immsrc = 3'b000;
        @(negedge clk);
        check("bp_a_ready", 64'(bus.in_ready), 64'd1);
        sb.push_back(mk(32'h00A00093, 32'h300, 32'd10));
        @(posedge clk); #1;
        bus.in_instr = 32'h00B00093;
        bus.in_pc    = 32'h304;
        @(negedge clk);
        check("bp_b_ready", 64'(bus.in_ready),  64'd1);
        check("bp_hold_a",  64'(bus.out_instr), 64'h00A00093);
        sb.push_back(mk(32'h00B00093, 32'h304, 32'd11));
        @(posedge clk); #1;
        bus.in_instr = 32'h00C00093;
        bus.in_pc    = 32'h308;
        repeat (2) begin
            @(negedge clk);
            check("bp_c_blocked", 64'(bus.in_ready),  64'd0);
            check("bp_stall_a",   64'(bus.out_instr), 64'h00A00093);
            check("bp_stall_v",   64'(bus.out_valid), 64'd1);
            @(posedge clk); #1;
        end
        ready_val = 1'b1;
        send(32'h00C00093, 32'h308, 3'b000, 32'd12);
        wait_drain();
        n = pop_cyc.size();
        check("bp_consecutive", 64'(pop_cyc[n-1] - pop_cyc[n-3]), 64'd2);
        check("bp_ready_back",  64'(bus.in_ready), 64'd1);

        // Flush with both slots full and D presented in the flush cycle
        ready_val = 1'b0;
        send(32'h11100093, 32'h400, 3'b000, 32'h111);
        send(32'h22200093, 32'h404, 3'b000, 32'h222);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hDDD00093;
        bus.in_pc    = 32'h408;
        flush        = 1'b1;
        @(negedge clk);
        check("fl_full_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check("fl_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk); #1;
        ready_val = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("fl_no_d", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Flush while in_ready is high: D still discarded
        ready_val = 1'b0;
        send(32'h33300093, 32'h500, 3'b000, 32'h333);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hDDD00093;
        bus.in_pc    = 32'h504;
        flush        = 1'b1;
        @(negedge clk);
        check("fl2_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("fl2_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset between edges with both slots full
        send(32'h44400093, 32'h600, 3'b000, 32'h444);
        send(32'h55500093, 32'h604, 3'b000, 32'h555);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid",  64'(bus.out_valid),  64'd0);
        check("ar_in_ready",   64'(bus.in_ready),   64'd1);
        check("ar_out_imm",    64'(bus.out_imm),    64'd0);
        check("ar_out_target", 64'(bus.out_target), 64'd0);
        check("ar_out_instr",  64'(bus.out_instr),  64'd0);
        check("ar_out_pc",     64'(bus.out_pc),     64'd0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        ready_val = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h06600093;
        bus.in_pc    = 32'h700;
        @(negedge clk);
        check("ar_g_ready", 64'(bus.in_ready), 64'd1);
        sb.push_back(mk(32'h06600093, 32'h700, 32'h66));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("ar_latency", 64'(bus.out_valid), 64'd1);
        check("ar_g_instr", 64'(bus.out_instr), 64'h06600093);
        @(posedge clk); #1;

        // Random stream with random back-pressure
        rnd_mode = 1'b1;
        repeat (40) begin
            ins = $urandom;
            pc  = $urandom;
            src = 3'($urandom_range(0, 7));
            send(ins, pc, src, ref_imm(ins, src, 1'b0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_mode  = 1'b0;
        ready_val = 1'b1;
        wait_drain();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
